quad_decoder_counter: RTL and testbench

Quadrature decoder with an up/down position counter. Receives the two-phase A/B stream produced by an incremental encoder (or by a quadrature generator driven from the existing up/down counters), derives direction from the phase order, and counts position up or down ×4 (one count per valid edge). Sits between external encoder pins and any logic that consumes the position count; flags illegal phase jumps.

---
 rtl/quad_decoder_counter.sv | 139 +++++++++++++
 tb/tb_quad_decoder_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// quad_decoder_counter
//   Quadrature decoder with an x4 up/down position counter. Each encoder
//   phase passes through a two-flop synchronizer and, when the macro
//   QDEC_GLITCH_FILTER_EN is defined, a per-phase stability filter. The
//   accepted phase pair is compared every cycle with the pair from the
//   previous cycle to step the counter or to flag an illegal jump.
//
// Parameters
//   WIDTH       position counter width
//   FILTER_LEN  cycles a new synchronized level must persist before it is
//               accepted (1..15). Used only with QDEC_GLITCH_FILTER_EN.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous active-high reset, clears all state
//   enable  1 = counting allowed, 0 = count/dir frozen (err still tracks)
//   clear   synchronous: count <= 0, err <= 0
//   qa, qb  encoder phases, asynchronous to clk
//   count   position count (wraps modulo 2^WIDTH)
//   dir     direction of last accepted step, 1 = up
//   step    one-cycle pulse per accepted count change
//   err     sticky, set when both phases change in the same cycle
module quad_decoder_counter #(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             qa,
  input  logic             qb,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_decoder_counter: FILTER_LEN must be in 1..15");
  end

  // Phase pairs are packed {A,B}.
  logic [1:0] s1, s2, ph, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {qa, qb};
      s2 <= s1;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  // Each phase counts cycles for which s2 disagrees with the accepted level;
  // any return to the accepted level restarts the count, so pulses shorter
  // than FILTER_LEN cycles never reach the decoder.
  logic [1:0]      ph_q;
  logic [1:0][3:0] flt_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_filter
    always_ff @(posedge clk) begin
      if (reset) begin
        ph_q[g]    <= 1'b0;
        flt_cnt[g] <= 4'd0;
      end else if (s2[g] == ph_q[g]) begin
        flt_cnt[g] <= 4'd0;
      end else if (flt_cnt[g] == 4'(FILTER_LEN - 1)) begin
        ph_q[g]    <= s2[g];
        flt_cnt[g] <= 4'd0;
      end else begin
        flt_cnt[g] <= flt_cnt[g] + 4'd1;
      end
    end
  end

  assign ph = ph_q;
  // Reset leaves the pipeline at 00 while the pins may sit anywhere; hold
  // decoding off until the pins' levels have propagated through s1, s2 and
  // the filter into prev, so the fill can never look like a transition.
  localparam int PRIME = 3 + FILTER_LEN;
`else
  assign ph = s2;
  localparam int PRIME = 3;
`endif

  // Map the Gray sequence 00,10,11,01 onto positions 0..3; the modulo-4
  // difference of positions is then 1 for up, 3 for down, 2 for illegal.
  function automatic logic [1:0] gray_pos(input logic [1:0] p);
    return {p[0], p[1] ^ p[0]};
  endfunction

  logic [1:0] delta;
  logic [4:0] prime;
  logic       primed;

  assign delta  = gray_pos(ph) - gray_pos(prev);
  assign primed = (prime == 5'(PRIME));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
      prev  <= 2'b00;
      prime <= 5'd0;
    end else begin
      // prev follows ph unconditionally so a clear, a disabled period or
      // the priming window consumes the transition instead of deferring it.
      prev <= ph;
      step <= 1'b0;
      if (!primed) prime <= prime + 5'd1;

      if (clear) begin
        count <= '0;
        err   <= 1'b0;
      end else if (primed) begin
        case (delta)
          2'd1: if (enable) begin
            count <= count + 1'b1;
            dir   <= 1'b1;
            step  <= 1'b1;
          end
          2'd3: if (enable) begin
            count <= count - 1'b1;
            dir   <= 1'b0;
            step  <= 1'b1;
          end
          2'd2:    err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
module tb_quad_decoder_counter;

  localparam int WIDTH = 4;
  localparam int FL    = 3;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 2 + FL;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset, enable, clear, qa, qb;
  logic [WIDTH-1:0] count;
  logic             dir, step, err;

  quad_decoder_counter #(.WIDTH(WIDTH), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .qa(qa), .qb(qb), .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int step_tot = 0;

  always @(negedge clk) if (step === 1'b1) step_tot++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       a, b, en, clr;
    logic [3:0] cnt;
    logic       dir, err;
    int         st;
  } vec_t;

  vec_t vec[$];
  int   base;

  initial begin
    // {qa, qb, enable, clear pulse, count, dir, err, step pulses}
    vec.push_back('{1,0,1,0, 4'd1, 1,0,1});   // up run 00->10->11->01->00->10->11
    vec.push_back('{1,1,1,0, 4'd2, 1,0,1});
    vec.push_back('{0,1,1,0, 4'd3, 1,0,1});
    vec.push_back('{0,0,1,0, 4'd4, 1,0,1});
    vec.push_back('{1,0,1,0, 4'd5, 1,0,1});
    vec.push_back('{1,1,1,0, 4'd6, 1,0,1});
    vec.push_back('{1,0,1,0, 4'd5, 0,0,1});   // down run back to 1
    vec.push_back('{0,0,1,0, 4'd4, 0,0,1});
    vec.push_back('{0,1,1,0, 4'd3, 0,0,1});
    vec.push_back('{1,1,1,0, 4'd2, 0,0,1});
    vec.push_back('{1,0,1,0, 4'd1, 0,0,1});
    vec.push_back('{0,0,1,0, 4'd0, 0,0,1});   // 1 -> 0 -> 15 -> 14
    vec.push_back('{0,1,1,0, 4'd15,0,0,1});
    vec.push_back('{1,1,1,0, 4'd14,0,0,1});
    vec.push_back('{0,0,1,0, 4'd14,0,1,0});   // 11->00 illegal
    vec.push_back('{0,0,1,1, 4'd0, 0,0,0});   // clear
    vec.push_back('{1,0,0,0, 4'd0, 0,0,0});   // disabled up run
    vec.push_back('{1,1,0,0, 4'd0, 0,0,0});
    vec.push_back('{0,1,0,0, 4'd0, 0,0,0});
    vec.push_back('{0,0,0,0, 4'd0, 0,0,0});
    vec.push_back('{0,0,1,0, 4'd0, 0,0,0});   // re-enable, static
    vec.push_back('{1,0,1,0, 4'd1, 1,0,1});
    vec.push_back('{0,0,1,0, 4'd0, 0,0,1});
    vec.push_back('{0,1,1,0, 4'd15,0,0,1});
    vec.push_back('{0,0,1,0, 4'd0, 1,0,1});   // up wrap 15 -> 0
    vec.push_back('{1,1,0,0, 4'd0, 1,1,0});   // illegal while disabled
    vec.push_back('{1,1,0,1, 4'd0, 1,0,0});
    vec.push_back('{1,1,1,0, 4'd0, 1,0,0});

    // reset with both phases high, then idle
    reset = 1; enable = 1; clear = 0; qa = 1; qb = 1;
    repeat (2) @(negedge clk);
    chk("rst count", count, 0);
    chk("rst dir", dir, 0);
    chk("rst step", step, 0);
    chk("rst err", err, 0);
    reset = 0; base = step_tot;
    repeat (10) @(negedge clk);
    chk("prime count", count, 0);
    chk("prime err", err, 0);
    chk("prime steps", step_tot - base, 0);

    reset = 1; qa = 0; qb = 0;
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);

    foreach (vec[i]) begin
      base = step_tot;
      qa = vec[i].a; qb = vec[i].b; enable = vec[i].en; clear = vec[i].clr;
      @(negedge clk);
      clear = 0;
      repeat (6) @(negedge clk);
      chk($sformatf("row%0d count", i), count, vec[i].cnt);
      chk($sformatf("row%0d dir", i), dir, vec[i].dir);
      chk($sformatf("row%0d err", i), err, vec[i].err);
      chk($sformatf("row%0d steps", i), step_tot - base, vec[i].st);
    end

    // clear coincides with a valid 11->01 transition: transition consumed
    qa = 0;
    repeat (LAT) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clrhit count", count, 0);
    chk("clrhit step", step, 0);
    chk("clrhit err", err, 0);
    repeat (5) @(negedge clk);
    chk("clrhit after", count, 0);
    qb = 0;                                   // 01->00 up
    repeat (6) @(negedge clk);
    chk("consumed count", count, 1);
    chk("consumed err", err, 0);

    // latency: 00->10, step exactly one cycle, LAT edges after sampling edge
    qa = 1;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      chk($sformatf("lat step e%0d", i - 1), step, (i == LAT + 1) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    chk("lat count", count, 2);

    // reset mid-rotation (phases at 10)
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst count", count, 0);
    chk("midrst dir", dir, 0);
    chk("midrst err", err, 0);
    base = step_tot;
    repeat (10) @(negedge clk);
    chk("midrst steps", step_tot - base, 0);
    chk("midrst err2", err, 0);
    qb = 1;                                   // 10->11 up
    repeat (6) @(negedge clk);
    chk("resume count", count, 1);
    chk("resume dir", dir, 1);

`ifdef QDEC_GLITCH_FILTER_EN
    // 2-cycle glitch on qa is discarded
    base = step_tot;
    qa = 0;
    repeat (2) @(negedge clk);
    qa = 1;
    repeat (10) @(negedge clk);
    chk("glitch steps", step_tot - base, 0);
    chk("glitch count", count, 1);
    chk("glitch err", err, 0);
    // stable change is accepted at E2+FILTER_LEN
    qa = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      chk($sformatf("flt step e%0d", i - 1), step, (i == LAT + 1) ? 1 : 0);
    end
    chk("flt count", count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
